// File: rtl/dram_burst_model_if.sv
// DRAM command/response channel between Top and the burst model.
// Signal names match Top's DRAM port so the wiring stays port-for-port.
interface dram_burst_model_if #(
    parameter int WORDS  = 16,
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 32
);
    logic                         io_dram_cmd_valid;
    logic                         io_dram_cmd_ready;
    logic [ADDR_W-1:0]            io_dram_cmd_bits_addr;
    logic                         io_dram_cmd_bits_isWr;
    logic [TAG_W-1:0]             io_dram_cmd_bits_tag;
    logic [TAG_W-1:0]             io_dram_cmd_bits_streamId;
    logic [WORDS-1:0][31:0]       io_dram_cmd_bits_wdata;
    logic                         io_dram_resp_valid;
    logic                         io_dram_resp_ready;
    logic [WORDS-1:0][31:0]       io_dram_resp_bits_rdata;
    logic [TAG_W-1:0]             io_dram_resp_bits_tag;
    logic [TAG_W-1:0]             io_dram_resp_bits_streamId;
    logic                         io_dram_resp_bits_isWr;

    modport master (
        output io_dram_cmd_valid, io_dram_cmd_bits_addr, io_dram_cmd_bits_isWr,
               io_dram_cmd_bits_tag, io_dram_cmd_bits_streamId, io_dram_cmd_bits_wdata,
               io_dram_resp_ready,
        input  io_dram_cmd_ready, io_dram_resp_valid, io_dram_resp_bits_rdata,
               io_dram_resp_bits_tag, io_dram_resp_bits_streamId, io_dram_resp_bits_isWr
    );

    modport slave (
        input  io_dram_cmd_valid, io_dram_cmd_bits_addr, io_dram_cmd_bits_isWr,
               io_dram_cmd_bits_tag, io_dram_cmd_bits_streamId, io_dram_cmd_bits_wdata,
               io_dram_resp_ready,
        output io_dram_cmd_ready, io_dram_resp_valid, io_dram_resp_bits_rdata,
               io_dram_resp_bits_tag, io_dram_resp_bits_streamId, io_dram_resp_bits_isWr
    );
endinterface

// File: rtl/dram_burst_model.sv
// Burst-addressed DRAM stand-in: in-order command queue with a minimum
// latency, commit-at-retire backing store and activity counters.
module dram_burst_model #(
    parameter int WORDS       = 16,
    parameter int ADDR_W      = 32,
    parameter int TAG_W       = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int QUEUE_DEPTH = 8,
    parameter int LATENCY     = 20
) (
    input  logic               clock,
    input  logic               reset,
    dram_burst_model_if.slave  io_dram,
    output logic [31:0]        rd_count,
    output logic [31:0]        wr_count,
    output logic [31:0]        stall_count
);
    localparam int BYTE_SH = $clog2(WORDS * 4);
    localparam int IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int QA_W    = $clog2(QUEUE_DEPTH);

    logic [IDX_W-1:0]       r_q_idx   [QUEUE_DEPTH];
    logic                   r_q_wr    [QUEUE_DEPTH];
    logic [TAG_W-1:0]       r_q_tag   [QUEUE_DEPTH];
    logic [TAG_W-1:0]       r_q_sid   [QUEUE_DEPTH];
    logic [15:0]            r_q_stamp [QUEUE_DEPTH];
    logic [WORDS-1:0][31:0] r_q_wdata [QUEUE_DEPTH];

    logic [QA_W-1:0]  r_wr_ptr;
    logic [QA_W-1:0]  r_rd_ptr;
    logic [QA_W:0]    r_count;
    logic             r_cmd_ready;
    logic [15:0]      r_cycle;
    logic             r_resp_valid;
    logic [TAG_W-1:0] r_resp_tag;
    logic [TAG_W-1:0] r_resp_sid;
    logic             r_resp_wr;
    logic [31:0]      r_rd_count;
    logic [31:0]      r_wr_count;
    logic [31:0]      r_stall_count;

    logic             w_push;
    logic             w_pop;
    logic [15:0]      w_head_age;
    logic             w_head_elig;
    logic             w_head_wr;
    logic [IDX_W-1:0] w_head_idx;
    logic [IDX_W-1:0] w_cmd_idx;
    logic [QA_W:0]    w_count_next;

    assign w_cmd_idx    = io_dram.io_dram_cmd_bits_addr[BYTE_SH +: IDX_W];
    assign w_push       = io_dram.io_dram_cmd_valid & r_cmd_ready & ~reset;
    assign w_head_age   = r_cycle - r_q_stamp[r_rd_ptr];
    assign w_head_elig  = (r_count != '0) && (w_head_age >= 16'(LATENCY));
    assign w_pop        = w_head_elig & (~r_resp_valid | io_dram.io_dram_resp_ready) & ~reset;
    assign w_head_wr    = r_q_wr[r_rd_ptr];
    assign w_head_idx   = r_q_idx[r_rd_ptr];
    assign w_count_next = r_count + (QA_W+1)'(w_push) - (QA_W+1)'(w_pop);

    // Queue payload storage carries no reset; the pointers define validity.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_q_idx[r_wr_ptr]   <= w_cmd_idx;
            r_q_wr[r_wr_ptr]    <= io_dram.io_dram_cmd_bits_isWr;
            r_q_tag[r_wr_ptr]   <= io_dram.io_dram_cmd_bits_tag;
            r_q_sid[r_wr_ptr]   <= io_dram.io_dram_cmd_bits_streamId;
            r_q_stamp[r_wr_ptr] <= r_cycle;
            r_q_wdata[r_wr_ptr] <= io_dram.io_dram_cmd_bits_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_cmd_ready   <= 1'b0;
            r_cycle       <= 16'd0;
            r_resp_valid  <= 1'b0;
            r_resp_tag    <= '0;
            r_resp_sid    <= '0;
            r_resp_wr     <= 1'b0;
            r_rd_count    <= 32'd0;
            r_wr_count    <= 32'd0;
            r_stall_count <= 32'd0;
        end else begin
            r_cycle <= r_cycle + 16'd1;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + QA_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + QA_W'(1);
            r_count     <= w_count_next;
            // Ready reflects the post-edge occupancy, so a full queue stays
            // not-ready for the whole cycle even if a pop happens in it.
            r_cmd_ready <= (w_count_next != (QA_W+1)'(QUEUE_DEPTH));
            if (w_pop) begin
                r_resp_valid <= 1'b1;
                r_resp_tag   <= r_q_tag[r_rd_ptr];
                r_resp_sid   <= r_q_sid[r_rd_ptr];
                r_resp_wr    <= w_head_wr;
                if (w_head_wr)
                    r_wr_count <= r_wr_count + 32'd1;
                else
                    r_rd_count <= r_rd_count + 32'd1;
            end else if (io_dram.io_dram_resp_ready) begin
                r_resp_valid <= 1'b0;
            end
            if (r_resp_valid && !io_dram.io_dram_resp_ready)
                r_stall_count <= r_stall_count + 32'd1;
        end
    end

    // One block RAM per word lane; writes commit only at retire so ordering
    // against reads follows issue order.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_lane
            logic [31:0] r_mem [MEM_DEPTH];
            logic [31:0] r_rdata;

            always_ff @(posedge clock) begin
                if (w_pop && w_head_wr)
                    r_mem[w_head_idx] <= r_q_wdata[r_rd_ptr][gi];
            end

            always_ff @(posedge clock) begin
                if (reset)
                    r_rdata <= 32'd0;
                else if (w_pop)
                    r_rdata <= w_head_wr ? 32'd0 : r_mem[w_head_idx];
            end

            assign io_dram.io_dram_resp_bits_rdata[gi] = r_rdata;
        end
    endgenerate

    assign io_dram.io_dram_cmd_ready          = r_cmd_ready;
    assign io_dram.io_dram_resp_valid         = r_resp_valid;
    assign io_dram.io_dram_resp_bits_tag      = r_resp_tag;
    assign io_dram.io_dram_resp_bits_streamId = r_resp_sid;
    assign io_dram.io_dram_resp_bits_isWr     = r_resp_wr;
    assign rd_count                           = r_rd_count;
    assign wr_count                           = r_wr_count;
    assign stall_count                        = r_stall_count;
endmodule

// File: doc/dram_burst_model.md
# dram_burst_model

Parametrised, synthesizable DRAM stand-in for Plasticine `Top` simulation and emulation builds: accepts burst read/write commands on the `io_dram_cmd_*` channel, stores write bursts in an internal burst-addressed array, and returns in-order responses on `io_dram_resp_*` after a programmable minimum latency. It replaces the always-ready, host-serviced DRAM path with real backpressure in both directions, a bounded in-flight queue and activity counters. It sits beside `Top`, wired port-for-port to its DRAM interface.

## Interface
Parameters:
- `WORDS` = 16: 32-bit words per burst (power of two, 1..16).
- `ADDR_W` = 32: byte-address width.
- `TAG_W` = 32: tag and streamId width.
- `MEM_DEPTH` = 256: bursts held in backing array (power of two).
- `QUEUE_DEPTH` = 8: in-flight command entries (power of two, >= 2).
- `LATENCY` = 20: minimum cycles from command accept to response valid (1..32767).

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `io_dram_cmd_valid`  in  1  command present.
- `io_dram_cmd_ready`  out  1  model can accept a command.
- `io_dram_cmd_bits_addr`  in  ADDR_W  byte address.
- `io_dram_cmd_bits_isWr`  in  1  1 = write burst.
- `io_dram_cmd_bits_tag`  in  TAG_W  echoed in response.
- `io_dram_cmd_bits_streamId`  in  TAG_W  echoed in response.
- `io_dram_cmd_bits_wdata_0..WORDS-1`  in  32 each  write burst data.
- `io_dram_resp_valid`  out  1  response present.
- `io_dram_resp_ready`  in  1  consumer accepts response.
- `io_dram_resp_bits_rdata_0..WORDS-1`  out  32 each  read data; 0 for write acks.
- `io_dram_resp_bits_tag`, `io_dram_resp_bits_streamId`  out  TAG_W each  echoed fields.
- `io_dram_resp_bits_isWr`  out  1  response is a write ack.
- `rd_count`, `wr_count`  out  32 each  retired reads / writes.
- `stall_count`  out  32  cycles with `io_dram_resp_valid & ~io_dram_resp_ready`.

## Operation
- Burst index = (addr >> log2(WORDS*4)) mod MEM_DEPTH; low address bits ignored.
- Accept: `io_dram_cmd_valid & io_dram_cmd_ready` at an edge pushes {addr index, isWr, tag, streamId, wdata, stamp} into the queue; stamp = free-running 16-bit cycle counter value.
- `io_dram_cmd_ready` = queue not full; registered, no same-cycle pass-through: full queue deasserts ready even if a pop occurs that cycle.
- Head eligible when (cycle − stamp) mod 2^16 >= LATENCY.
- Retire: eligible head and output register empty or being drained (`io_dram_resp_ready` high) → pop head into output register. Write: commit wdata to array at the retire edge; response rdata = 0, isWr = 1. Read: rdata = array contents at the retire edge (before any same-edge write, none possible since one retire per cycle).
- Strict FIFO order; commit at retire guarantees read-after-write and write-after-read ordering by issue order.
- Output register holds all resp fields stable while valid & ~ready.
- Counters increment on retire (rd/wr) and per stalled cycle; wrap at 2^32.

## Timing
- Reset values: `io_dram_cmd_ready` 1 on the first cycle after reset deasserts (0 while reset high), `io_dram_resp_valid` 0, resp data/tag/streamId/isWr 0, all counters 0, queue empty, cycle counter 0.
- Backing array is not reset; contents persist across reset.
- Reset mid-operation: queue and output register flushed, in-flight commands dropped with no response, uncommitted writes lost.
- Best-case latency: command accepted at edge k → `io_dram_resp_valid` high after edge k+LATENCY.
- Throughput: one accept and one retire per cycle sustained when LATENCY elapsed and `io_dram_resp_ready` high.
- Empty queue: no retire; full queue: ready 0 until pop edge, ready 1 after it.

## Test plan
- Single read after reset, LATENCY=20: read addr 0x40 tag 7 at edge 5 → resp_valid after edge 25, tag 7, isWr 0, rd_count 1.
- Write then read same burst: write addr 0x400 wdata_i = i+0x100, then read 0x400 → write ack (rdata 0), then read rdata_i = i+0x100, in issue order.
- Backpressure: QUEUE_DEPTH=8, resp_ready held 0, 10 commands offered → exactly 9 accepted (8 queued + 1 in output reg), cmd_ready 0, stall_count counts every held cycle, resp fields stable.
- Aliasing: MEM_DEPTH=256, WORDS=16, write addr 0x0 then read 0x4000 → returns written data.
- Reset mid-flight: 3 reads queued, reset pulsed 1 cycle → no responses, counters 0, subsequent read of a previously written burst returns the old data.
- Stamp wrap: run 70000 cycles idle, then read → still returns after exactly LATENCY cycles.
